// File: rtl/dram_tester_pkg.sv
// Shared types, widths and the data-pattern function for the DRAM pattern tester.
package dram_tester_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 16;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [ADDR_W-1:0] WORD_STRIDE = ADDR_W'(4);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    DONE
  } state_e;

  // Word content is derived from its own byte address so every location is distinct.
  function automatic logic [DATA_W-1:0] pattern_data(input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] seed);
    return {{(DATA_W - ADDR_W){1'b0}}, a} ^ seed;
  endfunction

endpackage

// File: rtl/dram_pattern_tester_if.sv
// CPU-side cache request/response bundle driven by the pattern tester.
interface dram_pattern_tester_if;
  import dram_tester_pkg::*;

  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_data;
  logic              cpu_req_rw;
  logic              cpu_req_valid;
  logic [DATA_W-1:0] cpu_res_data;
  logic              cpu_res_ready;

  modport master (
    output cpu_req_addr,
    output cpu_req_data,
    output cpu_req_rw,
    output cpu_req_valid,
    input  cpu_res_data,
    input  cpu_res_ready
  );

  modport slave (
    input  cpu_req_addr,
    input  cpu_req_data,
    input  cpu_req_rw,
    input  cpu_req_valid,
    output cpu_res_data,
    output cpu_res_ready
  );

endinterface

// File: rtl/dram_tester_watchdog.sv
// Stall watchdog: counts cycles a request waits for ready and flags the limit.
module dram_tester_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic fire
);

  // Fires during the TIMEOUT_CYC-th consecutive waiting cycle so valid drops on that edge.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (waiting) begin
      count_d = count_q + 16'd1;
    end
  end

  assign fire = waiting && !clear && (count_q == LIMIT);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dram_pattern_tester.sv
// Write/read-back pattern tester for the cache + DRAM path.
// Define DRAM_TESTER_WATCHDOG_EN to build in the request stall watchdog.
module dram_pattern_tester
  import dram_tester_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       NUM_WORDS   = 1024,
  parameter logic [DATA_W-1:0] SEED        = 32'hA5A5_5A5A,
  parameter int unsigned       TIMEOUT_CYC = 65535
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  dram_pattern_tester_if.master cpu,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;

  logic              wd_fire;
  logic              resp_hit;
  logic              rd_mismatch;
  logic [ADDR_W-1:0] next_addr;

`ifdef DRAM_TESTER_WATCHDOG_EN
  dram_tester_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear   (!valid_q),
    .waiting (valid_q && !cpu.cpu_res_ready),
    .fire    (wd_fire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wd_fire            = 1'b0;
`endif

  assign next_addr = addr_q + WORD_STRIDE;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rw_d        = rw_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    done_d      = done_q;

    // A response only counts while our request is actually outstanding.
    resp_hit    = valid_q && cpu.cpu_res_ready;
    rd_mismatch = (cpu.cpu_res_data != pattern_data(addr_q, SEED));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WR_REQ;
          idx_d       = '0;
          addr_d      = BASE_ADDR;
          data_d      = pattern_data(BASE_ADDR, SEED);
          rw_d        = RW_WRITE;
          err_d       = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          done_d      = 1'b0;
        end
      end

      WR_REQ: begin
        if (wd_fire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else if (resp_hit) begin
          state_d = WR_GAP;
        end
      end

      WR_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = RD_REQ;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          data_d  = '0;
          rw_d    = RW_READ;
        end else begin
          state_d = WR_REQ;
          idx_d   = idx_q + IDX_W'(1);
          addr_d  = next_addr;
          data_d  = pattern_data(next_addr, SEED);
        end
      end

      RD_REQ: begin
        if (wd_fire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else if (resp_hit) begin
          state_d = RD_GAP;
          if (rd_mismatch) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            // Saturation never returns the count to zero, so zero means "no mismatch yet".
            if (err_q == 16'd0) begin
              first_err_d = addr_q;
            end
          end
        end
      end

      RD_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_REQ;
          idx_d   = idx_q + IDX_W'(1);
          addr_d  = next_addr;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    busy_d  = (state_d == WR_REQ) || (state_d == WR_GAP) ||
              (state_d == RD_REQ) || (state_d == RD_GAP);
    pass_d  = (state_d == DONE) && (err_d == 16'd0) && !timeout_d;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rw_q        <= rw_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
    end
  end

  assign cpu.cpu_req_addr  = addr_q;
  assign cpu.cpu_req_data  = data_q;
  assign cpu.cpu_req_rw    = rw_q;
  assign cpu.cpu_req_valid = valid_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_count         = err_q;
  assign first_err_addr    = first_err_q;
  assign timeout           = timeout_q;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Self-checking bench: behavioural cache responder with a word-addressed memory model.
`timescale 1ns/1ps
module tb_dram_pattern_tester;

  localparam logic [26:0] TB_BASE    = 27'h100;
  localparam int          TB_WORDS   = 4;
  localparam logic [31:0] TB_SEED    = 32'hA5A5_5A5A;
  localparam int          TB_TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b1;
  logic        start   = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [26:0] first_err_addr;

  dram_pattern_tester_if bus ();

  dram_pattern_tester #(
    .BASE_ADDR   (TB_BASE),
    .NUM_WORDS   (TB_WORDS),
    .SEED        (TB_SEED),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .start          (start),
    .cpu            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout        (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dram [logic [26:0]];
  logic [31:0] flip [logic [26:0]];
  logic [26:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [26:0] rd_addr_log[$];
  logic [31:0] rd_reqdata_log[$];

  function automatic logic [31:0] exp_pat(input logic [26:0] a);
    return {5'b00000, a} ^ TB_SEED;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // Plays the cache: answers each request after a chosen delay, starting in the current cycle (cyc=1).
  task automatic run_session(input int fixed_delay, input bit rand_delay, input int start_again_at,
                             input bit abort_wr3, input int max_cyc,
                             output int lat, output int exp_lat);
    int vcnt;
    int cur_delay;
    int cyc;
    logic [31:0] rdata;
    vcnt = 0; cur_delay = 0; cyc = 1; lat = -1; exp_lat = 1;
    wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete(); rd_reqdata_log.delete();
    while (cyc <= max_cyc) begin
      if (done) begin
        lat = cyc;
        break;
      end
      start = (cyc == start_again_at);
      bus.cpu_res_ready = 1'b0;
      bus.cpu_res_data  = 32'h0;
      if (bus.cpu_req_valid) begin
        vcnt++;
        if (vcnt == 1) cur_delay = rand_delay ? int'($urandom_range(0, 5)) : fixed_delay;
        if (abort_wr3 && bus.cpu_req_rw && bus.cpu_req_addr == TB_BASE + 27'd8 && vcnt == 2) begin
          rst = 1'b1;
          lat = cyc;
          break;
        end
        if (vcnt == cur_delay + 1) begin
          bus.cpu_res_ready = 1'b1;
          exp_lat += vcnt + 1;
          if (bus.cpu_req_rw) begin
            dram[bus.cpu_req_addr] = bus.cpu_req_data;
            wr_addr_log.push_back(bus.cpu_req_addr);
            wr_data_log.push_back(bus.cpu_req_data);
            $display("[TB] cyc %0d WR addr=%h data=%h wait=%0d", cyc, bus.cpu_req_addr, bus.cpu_req_data, vcnt);
          end else begin
            rdata = dram.exists(bus.cpu_req_addr) ? dram[bus.cpu_req_addr] : 32'h0;
            if (flip.exists(bus.cpu_req_addr)) rdata ^= flip[bus.cpu_req_addr];
            bus.cpu_res_data = rdata;
            rd_addr_log.push_back(bus.cpu_req_addr);
            rd_reqdata_log.push_back(bus.cpu_req_data);
            $display("[TB] cyc %0d RD addr=%h resp=%h wait=%0d", cyc, bus.cpu_req_addr, rdata, vcnt);
          end
        end
      end else begin
        vcnt = 0;
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    start = 1'b0;
    bus.cpu_res_ready = 1'b0;
    bus.cpu_res_data  = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    bus.cpu_res_ready = 1'b0; bus.cpu_res_data = 32'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_tests++; if (bus.cpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.cpu_req_valid); end
    n_tests++; if (bus.cpu_req_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", bus.cpu_req_rw); end
    n_tests++; if (bus.cpu_req_addr !== 27'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.cpu_req_addr); end
    n_tests++; if (bus.cpu_req_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.cpu_req_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b expected 0", pass); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    n_tests++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    n_tests++; if (first_err_addr !== 27'h0) begin n_fail++; $display("FAIL reset_ferr: got %h expected 0", first_err_addr); end
    rst = 1'b0;
    @(posedge sys_clk); #1;
    n_tests++; if (busy !== 1'b0 || bus.cpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy=%b valid=%b expected 0/0", busy, bus.cpu_req_valid); end
  endtask

  task automatic test_ideal();
    int lat, exp_lat;
    flip.delete();
    pulse_start();
    n_tests++; if (bus.cpu_req_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL ideal_start_latency: valid=%b busy=%b expected 1/1", bus.cpu_req_valid, busy); end
    run_session(3, 1'b0, 0, 1'b0, 200, lat, exp_lat);
    n_tests++; if (lat !== 41) begin n_fail++; $display("FAIL ideal_latency: got %0d expected 41", lat); end
    n_tests++; if (done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("FAIL ideal_done_pass: done=%b pass=%b expected 1/1", done, pass); end
    n_tests++; if (err_count !== 16'd0 || first_err_addr !== 27'h0) begin n_fail++; $display("FAIL ideal_errs: err=%0d ferr=%h expected 0/0", err_count, first_err_addr); end
    n_tests++; if (timeout !== 1'b0 || busy !== 1'b0 || bus.cpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL ideal_idle_outputs: timeout=%b busy=%b valid=%b expected 0/0/0", timeout, busy, bus.cpu_req_valid); end
    n_tests++; if (wr_addr_log.size() != TB_WORDS || rd_addr_log.size() != TB_WORDS) begin n_fail++; $display("FAIL ideal_txn_count: wr=%0d rd=%0d expected %0d each", wr_addr_log.size(), rd_addr_log.size(), TB_WORDS); end
    for (int i = 0; i < TB_WORDS && i < wr_addr_log.size() && i < rd_addr_log.size(); i++) begin
      logic [26:0] a;
      a = TB_BASE + 27'(4 * i);
      n_tests++; if (wr_addr_log[i] !== a || wr_data_log[i] !== exp_pat(a)) begin n_fail++; $display("FAIL ideal_write%0d: got %h/%h expected %h/%h", i, wr_addr_log[i], wr_data_log[i], a, exp_pat(a)); end
      n_tests++; if (rd_addr_log[i] !== a || rd_reqdata_log[i] !== 32'h0) begin n_fail++; $display("FAIL ideal_read%0d: got %h/%h expected %h/0", i, rd_addr_log[i], rd_reqdata_log[i], a); end
    end
  endtask

  task automatic test_single_error();
    int lat, exp_lat;
    flip.delete();
    flip[TB_BASE + 27'd8] = 32'h1;
    pulse_start();
    run_session(3, 1'b0, 0, 1'b0, 200, lat, exp_lat);
    n_tests++; if (lat !== 41) begin n_fail++; $display("FAIL single_latency: got %0d expected 41", lat); end
    n_tests++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL single_err: got %0d expected 1", err_count); end
    n_tests++; if (first_err_addr !== 27'h108) begin n_fail++; $display("FAIL single_ferr: got %h expected 108", first_err_addr); end
    n_tests++; if (pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL single_pass: pass=%b done=%b expected 0/1", pass, done); end
  endtask

  task automatic test_two_errors();
    int lat, exp_lat;
    flip.delete();
    flip[TB_BASE + 27'd4]  = 32'h8000_0000;
    flip[TB_BASE + 27'd12] = 32'h0000_0100;
    pulse_start();
    run_session(3, 1'b0, 0, 1'b0, 200, lat, exp_lat);
    n_tests++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL two_err: got %0d expected 2", err_count); end
    n_tests++; if (first_err_addr !== 27'h104) begin n_fail++; $display("FAIL two_ferr: got %h expected 104", first_err_addr); end
    n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL two_pass: got %b expected 0", pass); end
  endtask

  task automatic test_done_restart();
    int lat, exp_lat;
    flip.delete();
    pulse_start();
    n_tests++; if (done !== 1'b0 || err_count !== 16'd0 || first_err_addr !== 27'h0) begin n_fail++; $display("FAIL restart_clear: done=%b err=%0d ferr=%h expected 0/0/0", done, err_count, first_err_addr); end
    n_tests++; if (bus.cpu_req_valid !== 1'b1 || bus.cpu_req_addr !== TB_BASE || bus.cpu_req_rw !== 1'b1) begin n_fail++; $display("FAIL restart_first_req: valid=%b addr=%h rw=%b expected 1/%h/1", bus.cpu_req_valid, bus.cpu_req_addr, bus.cpu_req_rw, TB_BASE); end
    run_session(3, 1'b0, 0, 1'b0, 200, lat, exp_lat);
    n_tests++; if (lat !== 41 || pass !== 1'b1 || err_count !== 16'd0) begin n_fail++; $display("FAIL restart_result: lat=%0d pass=%b err=%0d expected 41/1/0", lat, pass, err_count); end
  endtask

  task automatic test_start_while_busy();
    int lat, exp_lat;
    flip.delete();
    pulse_start();
    run_session(3, 1'b0, 12, 1'b0, 200, lat, exp_lat);
    n_tests++; if (lat !== 41) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 41", lat); end
    n_tests++; if (wr_addr_log.size() != TB_WORDS || pass !== 1'b1) begin n_fail++; $display("FAIL busy_start_result: writes=%0d pass=%b expected %0d/1", wr_addr_log.size(), pass, TB_WORDS); end
  endtask

  task automatic test_reset_mid();
    int lat, exp_lat;
    flip.delete();
    pulse_start();
    run_session(3, 1'b0, 0, 1'b1, 200, lat, exp_lat);
    n_tests++; if (lat < 0 || wr_addr_log.size() != 2) begin n_fail++; $display("FAIL mid_reached_wr3: lat=%0d writes=%0d expected >=0/2", lat, wr_addr_log.size()); end
    @(posedge sys_clk); #1;
    n_tests++; if (bus.cpu_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: valid=%b busy=%b done=%b expected 0/0/0", bus.cpu_req_valid, busy, done); end
    n_tests++; if (bus.cpu_req_addr !== 27'h0 || bus.cpu_req_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_req: addr=%h data=%h expected 0/0", bus.cpu_req_addr, bus.cpu_req_data); end
    rst = 1'b0;
    @(posedge sys_clk); #1;
    n_tests++; if (bus.cpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle: valid=%b expected 0", bus.cpu_req_valid); end
    pulse_start();
    n_tests++; if (bus.cpu_req_addr !== TB_BASE || bus.cpu_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_restart_addr: got %h valid=%b expected %h/1", bus.cpu_req_addr, bus.cpu_req_valid, TB_BASE); end
    run_session(3, 1'b0, 0, 1'b0, 200, lat, exp_lat);
    n_tests++; if (lat !== 41 || pass !== 1'b1) begin n_fail++; $display("FAIL mid_rerun: lat=%0d pass=%b expected 41/1", lat, pass); end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    int exp_err;
    logic [26:0] exp_ferr;
    logic [31:0] m;
    for (int it = 0; it < 8; it++) begin
      flip.delete();
      exp_err = 0;
      exp_ferr = 27'h0;
      for (int i = 0; i < TB_WORDS; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          m = $urandom;
          if (m == 32'h0) m = 32'h4;
          flip[TB_BASE + 27'(4 * i)] = m;
          if (exp_err == 0) exp_ferr = TB_BASE + 27'(4 * i);
          exp_err++;
        end
      end
      pulse_start();
      run_session(0, 1'b1, 0, 1'b0, 500, lat, exp_lat);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, exp_lat); end
      n_tests++; if (err_count !== 16'(exp_err) || first_err_addr !== exp_ferr) begin n_fail++; $display("FAIL rand%0d_errs: err=%0d ferr=%h expected %0d/%h", it, err_count, first_err_addr, exp_err, exp_ferr); end
      n_tests++; if (pass !== (exp_err == 0) || done !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL rand%0d_status: pass=%b done=%b timeout=%b expected %b/1/0", it, pass, done, timeout, (exp_err == 0)); end
    end
  endtask

`ifdef DRAM_TESTER_WATCHDOG_EN
  task automatic test_watchdog();
    int lat, exp_lat;
    flip.delete();
    pulse_start();
    run_session(1000, 1'b0, 0, 1'b0, 100, lat, exp_lat);
    n_tests++; if (lat !== TB_TIMEOUT + 1) begin n_fail++; $display("FAIL wd_latency: got %0d expected %0d", lat, TB_TIMEOUT + 1); end
    n_tests++; if (timeout !== 1'b1 || bus.cpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL wd_fire: timeout=%b valid=%b expected 1/0", timeout, bus.cpu_req_valid); end
    n_tests++; if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_status: done=%b pass=%b busy=%b expected 1/0/0", done, pass, busy); end
    pulse_start();
    n_tests++; if (timeout !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL wd_restart_clear: timeout=%b done=%b expected 0/0", timeout, done); end
    run_session(2, 1'b0, 0, 1'b0, 200, lat, exp_lat);
    n_tests++; if (lat !== exp_lat || pass !== 1'b1) begin n_fail++; $display("FAIL wd_recover: lat=%0d pass=%b expected %0d/1", lat, pass, exp_lat); end
  endtask
`endif

  initial begin
    bus.cpu_res_ready = 1'b0;
    bus.cpu_res_data  = 32'h0;
    test_reset();
    test_ideal();
    test_single_error();
    test_two_errors();
    test_done_restart();
    test_start_while_busy();
    test_reset_mid();
    test_random();
`ifdef DRAM_TESTER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
